// File: rtl/cmp_pkg.sv
// ============================================================================
//  Module      : cmp_pkg
//  Description : Shared definitions for the comparator operand loader:
//                operand width and the encoding of the load FSM states
//                (also driven out on load_state for the board LEDs).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cmp_pkg;

    localparam int CMP_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t ST_WAIT_A = 2'd0;
    localparam state_t ST_WAIT_B = 2'd1;
    localparam state_t ST_VALID  = 2'd2;

endpackage : cmp_pkg

`default_nettype wire

// File: rtl/cmp_operand_loader_if.sv
// ============================================================================
//  Module      : cmp_operand_loader_if
//  Description : Board-side bundle of the operand loader.
//                master : drives switches/buttons, observes operands
//                slave  : the loader itself
//  Signals     : sw_data, btn_load, btn_clr      (asynchronous board inputs)
//                a_out, b_out, operands_valid,
//                load_state                      (registered loader outputs)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface cmp_operand_loader_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) ();

    logic [WIDTH-1:0] sw_data;
    logic             btn_load;
    logic             btn_clr;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             operands_valid;
    state_t           load_state;

    modport master (
        output sw_data, btn_load, btn_clr,
        input  a_out, b_out, operands_valid, load_state
    );

    modport slave (
        input  sw_data, btn_load, btn_clr,
        output a_out, b_out, operands_valid, load_state
    );

endinterface : cmp_operand_loader_if

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
//  Module      : btn_debounce
//  Description : Synchronizer chain + saturating debounce counter + one-shot.
//                Emits a single-cycle pulse once the synchronized button has
//                been high for DEBOUNCE_CYCLES consecutive cycles; no further
//                pulse until the synchronized button drops back to 0.
//  Ports       : clk, rst_n  clock / async active-low reset
//                btn_i       asynchronous button input
//                pulse_o     registered one-cycle press pulse
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic btn_i,
    output logic      pulse_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] c_cnt_max = CW'(DEBOUNCE_CYCLES);
    // The pulse is registered, so it is armed one count early: it rises on
    // the same edge that takes the counter to c_cnt_max.
    localparam logic [CW-1:0] c_cnt_arm = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   pulse_q;
    logic                   pulse_d;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (!btn_s) begin
            cnt_d = '0;
        end else begin
            if (cnt_q != c_cnt_max) begin
                cnt_d = cnt_q + 1'b1;
            end
            // Saturation keeps cnt_q at max while held, so this fires once.
            pulse_d = (cnt_q == c_cnt_arm);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_i};
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/cmp_operand_loader.sv
// ============================================================================
//  Module      : cmp_operand_loader
//  Description : Operand stage for a signed comparator. Captures A, then B,
//                from one shared switch bank on debounced load presses and
//                flags when the pair is complete. A press while the pair is
//                valid starts a new pair (new A, B kept until replaced).
//  Ports       : clk, rst_n  clock / async active-low reset
//                bus         slave side of cmp_operand_loader_if
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module cmp_operand_loader
    import cmp_pkg::*;
#(
    parameter int WIDTH           = CMP_WIDTH,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    cmp_operand_loader_if.slave  bus
);

    logic [WIDTH-1:0]       sw_sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] clr_sync_q;
    logic [WIDTH-1:0]       sw_s;
    logic                   clr_s;
    logic                   load_pulse;

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       a_q, a_d;
    logic [WIDTH-1:0]       b_q, b_d;
    logic                   valid_q, valid_d;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_load_db (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.btn_load),
        .pulse_o (load_pulse)
    );

    assign sw_s  = sw_sync_q[SYNC_STAGES-1];
    assign clr_s = clr_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= '0;
            end
            clr_sync_q <= '0;
        end else begin
            sw_sync_q[0] <= bus.sw_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync_q[i] <= sw_sync_q[i-1];
            end
            clr_sync_q <= {clr_sync_q[SYNC_STAGES-2:0], bus.btn_clr};
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (clr_s) begin
            // Clear wins; a coincident load pulse is simply dropped.
            state_d = ST_WAIT_A;
            a_d     = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                ST_WAIT_A: begin
                    if (load_pulse) begin
                        a_d     = sw_s;
                        state_d = ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (load_pulse) begin
                        b_d     = sw_s;
                        state_d = ST_VALID;
                    end
                end
                ST_VALID: begin
                    if (load_pulse) begin
                        a_d     = sw_s;
                        state_d = ST_WAIT_B;
                    end
                end
                default: state_d = ST_WAIT_A;
            endcase
        end
        // Registered from next state so the flag tracks load_state exactly.
        valid_d = (state_d == ST_VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
        end
    end

    assign bus.a_out          = a_q;
    assign bus.b_out          = b_q;
    assign bus.operands_valid = valid_q;
    assign bus.load_state     = state_q;

endmodule : cmp_operand_loader

`default_nettype wire

// File: tb/tb_cmp_operand_loader.sv
// ============================================================================
//  Module      : tb_cmp_operand_loader
//  Description : Self-checking bench for cmp_operand_loader. A behavioural
//                model (input delay lines, press run-length, operand count)
//                is compared every cycle; directed scenarios add fixed
//                expectations.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cmp_operand_loader;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cmp_operand_loader_if #(.WIDTH(4)) bus ();

    cmp_operand_loader #(
        .WIDTH           (4),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_sw_pipe  [SYNC];
    logic       m_ld_pipe  [SYNC];
    logic       m_clr_pipe [SYNC];
    int         m_run    = 0;      // consecutive synced-high cycles of load
    logic       m_pulse  = 1'b0;
    int         m_loaded = 0;      // 0: none, 1: A only, 2: full pair
    logic [3:0] m_a      = 4'd0;
    logic [3:0] m_b      = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) begin
                m_sw_pipe[i]  = 4'd0;
                m_ld_pipe[i]  = 1'b0;
                m_clr_pipe[i] = 1'b0;
            end
            m_run = 0; m_pulse = 1'b0; m_loaded = 0; m_a = 4'd0; m_b = 4'd0;
        end else begin
            if (m_clr_pipe[SYNC-1]) begin
                m_loaded = 0; m_a = 4'd0; m_b = 4'd0;
            end else if (m_pulse) begin
                if (m_loaded == 1) begin
                    m_b = m_sw_pipe[SYNC-1]; m_loaded = 2;
                end else begin
                    m_a = m_sw_pipe[SYNC-1]; m_loaded = 1;
                end
            end
            m_run   = m_ld_pipe[SYNC-1] ? m_run + 1 : 0;
            m_pulse = (m_run == DEB);
            for (int i = SYNC - 1; i > 0; i--) begin
                m_sw_pipe[i]  = m_sw_pipe[i-1];
                m_ld_pipe[i]  = m_ld_pipe[i-1];
                m_clr_pipe[i] = m_clr_pipe[i-1];
            end
            m_sw_pipe[0]  = bus.sw_data;
            m_ld_pipe[0]  = bus.btn_load;
            m_clr_pipe[0] = bus.btn_clr;
        end
    end

    always @(negedge clk) begin
        check("a_out", bus.a_out, m_a);
        check("b_out", bus.b_out, m_b);
        check("load_state", bus.load_state, m_loaded);
        check("operands_valid", bus.operands_valid, m_loaded == 2);
        check("valid_vs_state", bus.operands_valid, bus.load_state == 2'd2);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] v, input int hold, input int gap);
        bus.sw_data  = v;
        bus.btn_load = 1'b1;
        tick(hold);
        bus.btn_load = 1'b0;
        tick(gap);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] a, input logic [3:0] b,
                              input logic v, input logic [1:0] st);
        check({tag, "_a"}, bus.a_out, a);
        check({tag, "_b"}, bus.b_out, b);
        check({tag, "_valid"}, bus.operands_valid, v);
        check({tag, "_state"}, bus.load_state, st);
    endtask

    initial begin
        bus.sw_data  = 4'd0;
        bus.btn_load = 1'b0;
        bus.btn_clr  = 1'b0;
        tick(3);
        expect_out("reset_held", 4'd0, 4'd0, 1'b0, 2'd0);
        rst_n = 1'b1;
        tick(2);
        expect_out("after_reset", 4'd0, 4'd0, 1'b0, 2'd0);

        // A = -3, B = +2
        press(4'b1101, 10, 8);
        expect_out("load_a", 4'b1101, 4'd0, 1'b0, 2'd1);
        press(4'b0010, 10, 8);
        expect_out("load_b", 4'b1101, 4'b0010, 1'b1, 2'd2);
        check("a_lt_b_signed", $signed(bus.a_out) < $signed(bus.b_out), 1'b1);

        // New A while pair valid: B kept, pair restarts
        press(4'b0111, 10, 8);
        expect_out("restart", 4'b0111, 4'b0010, 1'b0, 2'd1);

        // Switch activity without a press never reaches the operands
        for (int i = 0; i < 30; i++) begin
            bus.sw_data = 4'($urandom);
            tick(1);
        end
        expect_out("sw_toggle", 4'b0111, 4'b0010, 1'b0, 2'd1);

        // Async reset from VALID, checked before any clock edge
        press(4'b0101, 10, 8);
        expect_out("pre_rst", 4'b0111, 4'b0101, 1'b1, 2'd2);
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 4'd0, 4'd0, 1'b0, 2'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Short glitch: no pulse
        press(4'b1010, DEB - 1, 10);
        expect_out("glitch", 4'd0, 4'd0, 1'b0, 2'd0);
        // Long hold: exactly one capture
        press(4'b1001, 50, 10);
        expect_out("long_hold", 4'b1001, 4'd0, 1'b0, 2'd1);

        // Clear arriving on the same cycle as the load pulse in WAIT_B
        bus.sw_data  = 4'b0110;
        bus.btn_load = 1'b1;
        tick(DEB);
        bus.btn_clr  = 1'b1;
        tick(1);
        bus.btn_clr  = 1'b0;
        tick(3);
        bus.btn_load = 1'b0;
        tick(8);
        expect_out("clr_vs_load", 4'd0, 4'd0, 1'b0, 2'd0);

        // Randomized presses, switch noise and clears
        for (int k = 0; k < 80; k++) begin
            int hold;
            int gap;
            hold = int'($urandom_range(1, 9));
            gap  = int'($urandom_range(1, 6));
            bus.btn_load = 1'b1;
            for (int c = 0; c < hold + gap; c++) begin
                if (c == hold) bus.btn_load = 1'b0;
                bus.sw_data = 4'($urandom);
                bus.btn_clr = ($urandom_range(0, 15) == 0);
                tick(1);
            end
        end
        bus.btn_clr = 1'b0;
        tick(10);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_cmp_operand_loader

`default_nettype wire
